// File: rtl/dcache_types.sv
// dcache_types: shared FSM state, mux-select encodings and saturating-increment helper for the D-cache controller
package dcache_types;

    typedef enum logic [2:0] {IDLE, CHECK, WRITEBACK, FILL, REFETCH} dcache_state_t;
    typedef enum logic {DSEL_CPU, DSEL_PMEM} data_sel_t;
    typedef enum logic {ASEL_CPU, ASEL_VICTIM} addr_sel_t;

    localparam int PERF_W = 32;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && v != '1) ? v + PERF_W'(1) : v;
    endfunction

endpackage

// File: rtl/dcache_perf_ctr.sv
// dcache_perf_ctr: three saturating 32-bit event counters (hits, misses, writebacks)
module dcache_perf_ctr
    import dcache_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_inc_hit,
    input  logic              i_inc_miss,
    input  logic              i_inc_wb,
    output logic [PERF_W-1:0] o_hits,
    output logic [PERF_W-1:0] o_misses,
    output logic [PERF_W-1:0] o_writebacks
);

    // Counters stick at all-ones rather than wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            o_hits       <= '0;
            o_misses     <= '0;
            o_writebacks <= '0;
        end else begin
            o_hits       <= sat_inc(o_hits, i_inc_hit);
            o_misses     <= sat_inc(o_misses, i_inc_miss);
            o_writebacks <= sat_inc(o_writebacks, i_inc_wb);
        end
    end

endmodule

// File: rtl/dcache_control.sv
// dcache_control: 2-way write-back D-cache controller FSM; DCACHE_PERF_EN adds hit/miss/writeback counters
module dcache_control
    import dcache_types::*;
#(
    parameter int s_index  = 5,
    parameter int num_ways = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [s_index-1:0] mem_index,
    input  logic [1:0]         hit,
    input  logic [1:0]         dirty,
    input  logic               lru,
    input  logic               pmem_resp,
    output logic               mem_resp,
    output logic               array_read,
    output logic [1:0]         tag_load,
    output logic [1:0]         dirty_load,
    output logic               dirty_in,
    output logic               lru_load,
    output logic               lru_in,
    output logic [1:0]         data_we,
    output logic               data_sel,
    output logic               way_sel,
    output logic               addr_sel,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [s_index-1:0] index_q
`ifdef DCACHE_PERF_EN
    ,
    output logic [PERF_W-1:0]  perf_hits,
    output logic [PERF_W-1:0]  perf_misses,
    output logic [PERF_W-1:0]  perf_writebacks
`endif
);

    if (num_ways != 2) begin : g_bad_ways
        $error("dcache_control supports num_ways == 2 only");
    end

    dcache_state_t r_state, w_state_n;
    logic          r_victim;
    logic          w_hit_way;
    logic          w_any_hit;

    // Way 0 wins if both ways ever report a hit
    assign w_hit_way = ~hit[0];
    assign w_any_hit = |hit;

    // State, victim way and array index registers; index follows the CPU only while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_victim <= 1'b0;
            index_q  <= '0;
        end else begin
            r_state <= w_state_n;
            if (r_state == IDLE)
                index_q <= mem_index;
            if (r_state == CHECK && !w_any_hit)
                r_victim <= lru;
        end
    end

    // Next state and all array/pmem controls; everything held low while rst is asserted
    always_comb begin
        w_state_n  = r_state;
        mem_resp   = 1'b0;
        array_read = 1'b0;
        tag_load   = 2'b00;
        dirty_load = 2'b00;
        dirty_in   = 1'b0;
        lru_load   = 1'b0;
        lru_in     = 1'b0;
        data_we    = 2'b00;
        data_sel   = DSEL_CPU;
        way_sel    = 1'b0;
        addr_sel   = ASEL_CPU;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    array_read = 1'b1;
                    w_state_n  = (mem_read || mem_write) ? CHECK : IDLE;
                end
                CHECK: begin
                    if (w_any_hit) begin
                        mem_resp  = 1'b1;
                        way_sel   = w_hit_way;
                        lru_load  = 1'b1;
                        lru_in    = ~w_hit_way;
                        w_state_n = IDLE;
                        if (mem_write) begin
                            data_we[w_hit_way]    = 1'b1;
                            data_sel              = DSEL_CPU;
                            dirty_load[w_hit_way] = 1'b1;
                            dirty_in              = 1'b1;
                        end
                    end else begin
                        way_sel   = lru;
                        w_state_n = dirty[lru] ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = ASEL_VICTIM;
                    way_sel    = r_victim;
                    if (pmem_resp) begin
                        dirty_load[r_victim] = 1'b1;
                        w_state_n            = FILL;
                    end
                end
                FILL: begin
                    pmem_read = 1'b1;
                    addr_sel  = ASEL_CPU;
                    way_sel   = r_victim;
                    if (pmem_resp) begin
                        data_we[r_victim]  = 1'b1;
                        data_sel           = DSEL_PMEM;
                        tag_load[r_victim] = 1'b1;
                        w_state_n          = REFETCH;
                    end
                end
                REFETCH: begin
                    array_read = 1'b1;
                    w_state_n  = CHECK;
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    hit_onehot: assert property (@(posedge clk) disable iff (rst) (r_state == CHECK) |-> (hit != 2'b11));
    pmem_excl:  assert property (@(posedge clk) !(pmem_read && pmem_write));

`ifdef DCACHE_PERF_EN
    logic r_refetch;

    // Marks the CHECK that follows a refetch so its guaranteed hit is not counted
    always_ff @(posedge clk) begin
        if (rst)
            r_refetch <= 1'b0;
        else if (r_state == REFETCH)
            r_refetch <= 1'b1;
        else if (r_state == CHECK)
            r_refetch <= 1'b0;
    end

    dcache_perf_ctr u_perf (
        .clk          (clk),
        .rst          (rst),
        .i_inc_hit    (r_state == CHECK && w_any_hit && !r_refetch),
        .i_inc_miss   (r_state == CHECK && !w_any_hit),
        .i_inc_wb     (r_state == WRITEBACK && pmem_resp),
        .o_hits       (perf_hits),
        .o_misses     (perf_misses),
        .o_writebacks (perf_writebacks)
    );
`endif

endmodule

// File: tb/tb_dcache_control.sv
// tb_dcache_control: directed self-checking bench for the D-cache controller FSM
module tb_dcache_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mem_read = 1'b0, mem_write = 1'b0;
    logic [4:0] mem_index = '0;
    logic [1:0] hit = '0, dirty = '0;
    logic       lru = 1'b0, pmem_resp = 1'b0;
    logic       mem_resp, array_read, dirty_in, lru_load, lru_in, data_sel, way_sel, addr_sel;
    logic       pmem_read, pmem_write;
    logic [1:0] tag_load, dirty_load, data_we;
    logic [4:0] index_q;
`ifdef DCACHE_PERF_EN
    logic [31:0] perf_hits, perf_misses, perf_writebacks;
`endif

    int npass = 0, ntot = 0;

    int         cyc, n_rd, n_wr;
    logic       overlap;
    logic [1:0] fill_tl, fill_dwe, wb_dl;
    logic       fill_ds, fill_as, wb_di, wb_as, wb_ws;
    logic [1:0] r_dwe, r_dl;
    logic       r_ds, r_di, r_ll, r_li, r_ws;
    logic [4:0] r_idx;

    dcache_control #(.s_index(5), .num_ways(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_index  (mem_index),
        .hit        (hit),
        .dirty      (dirty),
        .lru        (lru),
        .pmem_resp  (pmem_resp),
        .mem_resp   (mem_resp),
        .array_read (array_read),
        .tag_load   (tag_load),
        .dirty_load (dirty_load),
        .dirty_in   (dirty_in),
        .lru_load   (lru_load),
        .lru_in     (lru_in),
        .data_we    (data_we),
        .data_sel   (data_sel),
        .way_sel    (way_sel),
        .addr_sel   (addr_sel),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .index_q    (index_q)
`ifdef DCACHE_PERF_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses),
        .perf_writebacks (perf_writebacks)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one CPU request to completion, modelling memory latency and the post-fill array contents
    task automatic run_req(input logic wr, input logic [4:0] idx, input logic [1:0] h,
                           input logic [1:0] d, input logic l, input int lat);
        int   hold = 0;
        logic done = 1'b0;
        logic filled;
        cyc = 0; n_rd = 0; n_wr = 0; overlap = 1'b0;
        fill_tl = '0; fill_dwe = '0; fill_ds = 1'b0; fill_as = 1'b1;
        wb_dl = '0; wb_di = 1'b1; wb_as = 1'b0; wb_ws = 1'b0;
        r_dwe = '0; r_dl = '0; r_ds = 1'b1; r_di = 1'b0; r_ll = 1'b0; r_li = 1'b0; r_ws = 1'b0; r_idx = '0;
        mem_read = !wr; mem_write = wr; mem_index = idx; hit = h; dirty = d; lru = l;
        while (!done && cyc < 100) begin
            cyc++;
            filled = 1'b0;
            #1;
            if (pmem_read || pmem_write) begin
                hold++;
                if (hold == lat) pmem_resp = 1'b1;
            end
            #1;
            if (pmem_read && pmem_write) overlap = 1'b1;
            n_rd += int'(pmem_read);
            n_wr += int'(pmem_write);
            if (pmem_resp && pmem_write) begin
                wb_dl = dirty_load; wb_di = dirty_in; wb_as = addr_sel; wb_ws = way_sel;
            end
            if (pmem_resp && pmem_read) begin
                fill_tl = tag_load; fill_dwe = data_we; fill_ds = data_sel; fill_as = addr_sel;
                filled = 1'b1;
            end
            if (mem_resp) begin
                r_dwe = data_we; r_dl = dirty_load; r_ds = data_sel; r_di = dirty_in;
                r_ll = lru_load; r_li = lru_in; r_ws = way_sel; r_idx = index_q;
                done = 1'b1;
            end
            if (pmem_resp) hold = 0;
            @(posedge clk);
            #1;
            pmem_resp = 1'b0;
            if (filled) hit = fill_tl;
        end
        mem_read = 1'b0; mem_write = 1'b0; hit = '0; dirty = '0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        ntot++; if ({mem_resp, array_read, pmem_read, pmem_write, lru_load, tag_load, data_we} !== '0) $display("FAIL reset_outputs got %b exp 0", {mem_resp, array_read, pmem_read, pmem_write, lru_load, tag_load, data_we}); else npass++;
        ntot++; if (index_q !== 5'd0) $display("FAIL reset_index got %0d exp 0", index_q); else npass++;
        rst = 1'b0;
        #1;
        ntot++; if (array_read !== 1'b1) $display("FAIL idle_array_read got %b exp 1", array_read); else npass++;
        tick();
    endtask

    task automatic test_cold_read();
        run_req(1'b0, 5'd3, 2'b00, 2'b00, 1'b0, 5);
        ntot++; if (cyc !== 9) $display("FAIL cold_latency got %0d exp 9", cyc); else npass++;
        ntot++; if (n_rd !== 5 || n_wr !== 0) $display("FAIL cold_pmem_cycles got rd=%0d wr=%0d exp rd=5 wr=0", n_rd, n_wr); else npass++;
        ntot++; if (fill_tl !== 2'b01 || fill_dwe !== 2'b01 || fill_ds !== 1'b1 || fill_as !== 1'b0) $display("FAIL cold_fill got tl=%b we=%b ds=%b as=%b exp 01 01 1 0", fill_tl, fill_dwe, fill_ds, fill_as); else npass++;
        ntot++; if (r_ll !== 1'b1 || r_li !== 1'b1 || r_ws !== 1'b0) $display("FAIL cold_lru got ll=%b li=%b ws=%b exp 1 1 0", r_ll, r_li, r_ws); else npass++;
        ntot++; if (r_idx !== 5'd3) $display("FAIL cold_index got %0d exp 3", r_idx); else npass++;
    endtask

    task automatic test_read_hit();
        run_req(1'b0, 5'd4, 2'b10, 2'b00, 1'b0, 1);
        ntot++; if (cyc !== 2) $display("FAIL rhit_latency got %0d exp 2", cyc); else npass++;
        ntot++; if (r_ll !== 1'b1 || r_li !== 1'b0 || r_ws !== 1'b1) $display("FAIL rhit_lru got ll=%b li=%b ws=%b exp 1 0 1", r_ll, r_li, r_ws); else npass++;
        ntot++; if (n_rd + n_wr !== 0 || r_dwe !== 2'b00 || r_dl !== 2'b00) $display("FAIL rhit_side_effects got pmem=%0d we=%b dl=%b exp 0 00 00", n_rd + n_wr, r_dwe, r_dl); else npass++;
    endtask

    task automatic test_write_hit();
        run_req(1'b1, 5'd9, 2'b01, 2'b00, 1'b1, 1);
        ntot++; if (cyc !== 2) $display("FAIL whit_latency got %0d exp 2", cyc); else npass++;
        ntot++; if (r_dwe !== 2'b01 || r_ds !== 1'b0) $display("FAIL whit_data got we=%b ds=%b exp 01 0", r_dwe, r_ds); else npass++;
        ntot++; if (r_dl !== 2'b01 || r_di !== 1'b1) $display("FAIL whit_dirty got dl=%b di=%b exp 01 1", r_dl, r_di); else npass++;
        ntot++; if (r_li !== 1'b1 || r_ll !== 1'b1) $display("FAIL whit_lru got ll=%b li=%b exp 1 1", r_ll, r_li); else npass++;
    endtask

    task automatic test_dirty_miss();
        run_req(1'b0, 5'd17, 2'b00, 2'b10, 1'b1, 3);
        ntot++; if (cyc !== 10) $display("FAIL dmiss_latency got %0d exp 10", cyc); else npass++;
        ntot++; if (n_wr !== 3 || n_rd !== 3) $display("FAIL dmiss_pmem_cycles got rd=%0d wr=%0d exp 3 3", n_rd, n_wr); else npass++;
        ntot++; if (overlap !== 1'b0) $display("FAIL dmiss_overlap got %b exp 0", overlap); else npass++;
        ntot++; if (wb_as !== 1'b1 || wb_ws !== 1'b1 || wb_dl !== 2'b10 || wb_di !== 1'b0) $display("FAIL dmiss_wb got as=%b ws=%b dl=%b di=%b exp 1 1 10 0", wb_as, wb_ws, wb_dl, wb_di); else npass++;
        ntot++; if (fill_tl !== 2'b10 || fill_dwe !== 2'b10) $display("FAIL dmiss_fill got tl=%b we=%b exp 10 10", fill_tl, fill_dwe); else npass++;
        ntot++; if (r_ws !== 1'b1 || r_li !== 1'b0) $display("FAIL dmiss_resp got ws=%b li=%b exp 1 0", r_ws, r_li); else npass++;
    endtask

    task automatic test_reset_in_fill();
        mem_read = 1'b1; mem_index = 5'd7; hit = '0; dirty = '0; lru = 1'b0;
        tick();
        tick();
        tick();
        ntot++; if (pmem_read !== 1'b1) $display("FAIL rfill_pmem_before got %b exp 1", pmem_read); else npass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        ntot++; if (pmem_read !== 1'b0 || array_read !== 1'b1) $display("FAIL rfill_idle got pr=%b ar=%b exp 0 1", pmem_read, array_read); else npass++;
        mem_read = 1'b0;
        tick();
        run_req(1'b0, 5'd7, 2'b00, 2'b00, 1'b0, 2);
        ntot++; if (n_rd !== 2 || cyc !== 6) $display("FAIL rfill_remiss got rd=%0d cyc=%0d exp 2 6", n_rd, cyc); else npass++;
    endtask

`ifdef DCACHE_PERF_EN
    task automatic test_perf();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_req(1'b0, 5'd1, 2'b01, 2'b00, 1'b0, 1);
        run_req(1'b1, 5'd2, 2'b10, 2'b00, 1'b0, 1);
        run_req(1'b0, 5'd3, 2'b01, 2'b00, 1'b1, 1);
        run_req(1'b0, 5'd4, 2'b00, 2'b00, 1'b0, 2);
        run_req(1'b1, 5'd5, 2'b00, 2'b01, 1'b1, 2);
        run_req(1'b0, 5'd6, 2'b00, 2'b01, 1'b0, 2);
        ntot++; if (perf_hits !== 32'd3) $display("FAIL perf_hits got %0d exp 3", perf_hits); else npass++;
        ntot++; if (perf_misses !== 32'd3) $display("FAIL perf_misses got %0d exp 3", perf_misses); else npass++;
        ntot++; if (perf_writebacks !== 32'd1) $display("FAIL perf_writebacks got %0d exp 1", perf_writebacks); else npass++;
    endtask
`endif

    initial begin
        test_reset();
        test_cold_read();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_reset_in_fill();
`ifdef DCACHE_PERF_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
